// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch resolve unit
//
// Purpose: request kind encoding, branch funct3 codes and FSM state type
//          shared by branch_cmp and branch_resolve_unit.
// Ports:   none (package).

package branch_pkg;

  typedef enum logic [1:0] {
    BR_KIND_BRANCH = 2'b00,
    BR_KIND_JAL    = 2'b01,
    BR_KIND_JALR   = 2'b10,
    BR_KIND_RSVD   = 2'b11
  } br_kind_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    RESP = 2'b10
  } br_state_t;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluator
//
// Purpose: evaluates the six conditional branch comparisons on two operands.
// Ports:
//   funct3_i   in  3     branch condition code
//   a_i        in  XLEN  first operand (rs1)
//   b_i        in  XLEN  second operand (rs2)
//   cond_o     out 1     condition holds
//   illegal_o  out 1     funct3 is not a branch condition (010/011)

module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            cond_o,
  output logic            illegal_o
);

  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = (a_i == b_i);
      F3_BNE:  cond_o = (a_i != b_i);
      F3_BLT:  cond_o = ($signed(a_i) <  $signed(b_i));
      F3_BGE:  cond_o = ($signed(a_i) >= $signed(b_i));
      F3_BLTU: cond_o = (a_i <  b_i);
      F3_BGEU: cond_o = (a_i >= b_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch/jump resolution unit with request/response handshake
//
// Purpose: resolves BRANCH/JAL/JALR requests into taken, target, link and
//          next-PC, flagging misaligned and illegal cases. Optional branch
//          history table enabled by macro BRANCH_PREDICT_EN.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, not in reset)
//   req_kind, req_funct3  operation kind and branch condition
//   req_pc, req_rs1, req_rs2, req_imm   operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_taken, rsp_target, rsp_pc_next, rsp_link   results
//   rsp_misaligned, rsp_illegal                    exception flags
//   rsp_pred_taken, rsp_mispredict                 predictor outputs (0 without BHT)

module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_taken,
  output logic [XLEN-1:0] rsp_target,
  output logic [XLEN-1:0] rsp_pc_next,
  output logic [XLEN-1:0] rsp_link,
  output logic            rsp_misaligned,
  output logic            rsp_illegal,
  output logic            rsp_pred_taken,
  output logic            rsp_mispredict
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  br_state_t state_q, state_d;

  // Latched request
  br_kind_t        kind_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;

  // Evaluation results (valid while state_q == EVAL)
  logic            cmp_cond, cmp_illegal;
  logic            is_jump, ev_illegal, ev_taken, ev_mis;
  logic [XLEN-1:0] ev_target, ev_link, ev_pc_next, pc_plus4, jalr_sum;
  logic            ev_pred, ev_mispred;

  logic accept;

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign accept    = (state_q == IDLE) && req_valid;

  // Request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q <= BR_KIND_BRANCH;
      f3_q   <= '0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      kind_q <= br_kind_t'(req_kind);
      f3_q   <= req_funct3;
      pc_q   <= req_pc;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      imm_q  <= req_imm;
    end
  end

  // Datapath
  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3_i  (f3_q),
    .a_i       (rs1_q),
    .b_i       (rs2_q),
    .cond_o    (cmp_cond),
    .illegal_o (cmp_illegal)
  );

  always_comb begin
    is_jump    = (kind_q == BR_KIND_JAL) || (kind_q == BR_KIND_JALR);
    ev_illegal = (kind_q == BR_KIND_RSVD) ||
                 ((kind_q == BR_KIND_BRANCH) && cmp_illegal);
    ev_taken   = !ev_illegal && (is_jump || cmp_cond);
    pc_plus4   = pc_q + FOUR;
    jalr_sum   = rs1_q + imm_q;
    ev_target  = (kind_q == BR_KIND_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
    ev_link    = is_jump ? pc_plus4 : '0;
    // Misalignment only matters when the transfer actually happens.
    ev_mis     = ev_taken && (ev_target[1:0] != 2'b00);
    // A misaligned taken transfer keeps the faulting PC for the trap logic.
    if (ev_illegal || !ev_taken) ev_pc_next = pc_plus4;
    else if (ev_mis)             ev_pc_next = pc_q;
    else                         ev_pc_next = ev_target;
  end

`ifdef BRANCH_PREDICT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic             pred_q;
  logic [IDX_W-1:0] acc_idx, upd_idx;

  assign acc_idx = req_pc[IDX_W+1:2];
  assign upd_idx = pc_q[IDX_W+1:2];

  // Accept (IDLE) and update (EVAL) never coincide, so no read/write bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      pred_q <= 1'b0;
    end else begin
      if (accept) pred_q <= bht_q[acc_idx][1];
      if ((state_q == EVAL) && (kind_q == BR_KIND_BRANCH) && !ev_illegal) begin
        if (ev_taken && (bht_q[upd_idx] != 2'b11))
          bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
        else if (!ev_taken && (bht_q[upd_idx] != 2'b00))
          bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    ev_pred    = 1'b0;
    ev_mispred = 1'b0;
    if (kind_q == BR_KIND_BRANCH) begin
      ev_pred    = pred_q;
      ev_mispred = (pred_q != ev_taken);
    end else if (is_jump) begin
      ev_pred    = 1'b1;
    end
  end
`else
  assign ev_pred    = 1'b0;
  assign ev_mispred = 1'b0;
`endif

  // Response registers: loaded once in EVAL, held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_taken      <= 1'b0;
      rsp_target     <= '0;
      rsp_pc_next    <= '0;
      rsp_link       <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
      rsp_pred_taken <= 1'b0;
      rsp_mispredict <= 1'b0;
    end else if (state_q == EVAL) begin
      rsp_taken      <= ev_taken;
      rsp_target     <= ev_target;
      rsp_pc_next    <= ev_pc_next;
      rsp_link       <= ev_link;
      rsp_misaligned <= ev_mis;
      rsp_illegal    <= ev_illegal;
      rsp_pred_taken <= ev_pred;
      rsp_mispredict <= ev_mispred;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc, req_rs1, req_rs2, req_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_taken;
  logic [31:0] rsp_target, rsp_pc_next, rsp_link;
  logic        rsp_misaligned, rsp_illegal, rsp_pred_taken, rsp_mispredict;

  int n_checks = 0;
  int n_errors = 0;

`ifdef BRANCH_PREDICT_EN
  localparam logic PRED_ON = 1'b1;
`else
  localparam logic PRED_ON = 1'b0;
`endif

  branch_resolve_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_kind       (req_kind),
    .req_funct3     (req_funct3),
    .req_pc         (req_pc),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_imm        (req_imm),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_taken      (rsp_taken),
    .rsp_target     (rsp_target),
    .rsp_pc_next    (rsp_pc_next),
    .rsp_link       (rsp_link),
    .rsp_misaligned (rsp_misaligned),
    .rsp_illegal    (rsp_illegal),
    .rsp_pred_taken (rsp_pred_taken),
    .rsp_mispredict (rsp_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    req_kind   = k;
    req_funct3 = f3;
    req_pc     = pc;
    req_rs1    = a;
    req_rs2    = b;
    req_imm    = imm;
    req_valid  = 1'b1;
  endtask

  // Accept at edge N, check EVAL gap, then check rsp_valid after edge N+1.
  task automatic issue(input string tag, input logic [1:0] k, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    drive(k, f3, pc, a, b, imm);
    chk({tag, ".ready_idle"}, req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    chk({tag, ".valid_eval"}, rsp_valid, 1'b0);
    chk({tag, ".ready_eval"}, req_ready, 1'b0);
    cyc();
    chk({tag, ".valid_resp"}, rsp_valid, 1'b1);
  endtask

  task automatic expect_rsp(input string tag, input logic taken, input logic [31:0] target,
                            input logic [31:0] pc_next, input logic [31:0] link,
                            input logic mis, input logic ill);
    chk({tag, ".taken"},   rsp_taken, taken);
    chk({tag, ".target"},  rsp_target, target);
    chk({tag, ".pc_next"}, rsp_pc_next, pc_next);
    chk({tag, ".link"},    rsp_link, link);
    chk({tag, ".mis"},     rsp_misaligned, mis);
    chk({tag, ".illegal"}, rsp_illegal, ill);
  endtask

  task automatic retire(input string tag);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk({tag, ".valid_retired"}, rsp_valid, 1'b0);
    chk({tag, ".ready_retired"}, req_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    drive(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    req_valid = 1'b0;
    cyc();
    cyc();
    chk("rst.valid",   rsp_valid, 1'b0);
    chk("rst.ready",   req_ready, 1'b0);
    chk("rst.taken",   rsp_taken, 1'b0);
    chk("rst.pc_next", rsp_pc_next, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", req_ready, 1'b1);

    // BEQ taken, negative offset
    issue("beq", 2'b00, 3'b000, 32'h0, 32'h2a, 32'h2a, 32'hFFFF_FFF4);
    expect_rsp("beq", 1'b1, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'h0, 1'b0, 1'b0);
    retire("beq");

    // Signed vs unsigned on the same operands
    issue("blt", 2'b00, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h10);
    expect_rsp("blt", 1'b1, 32'h110, 32'h110, 32'h0, 1'b0, 1'b0);
    retire("blt");
    issue("bltu", 2'b00, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h10);
    expect_rsp("bltu", 1'b0, 32'h110, 32'h104, 32'h0, 1'b0, 1'b0);
    retire("bltu");

    // JALR: bit 0 cleared, bit 1 set -> misaligned, pc_next holds faulting pc
    issue("jalr", 2'b10, 3'b000, 32'h200, 32'h1003, 32'h0, 32'h4);
    expect_rsp("jalr", 1'b1, 32'h1006, 32'h200, 32'h204, 1'b1, 1'b0);
    chk("jalr.pred", rsp_pred_taken, PRED_ON);
    chk("jalr.mispred", rsp_mispredict, 1'b0);
    retire("jalr");

    // JAL aligned
    issue("jal", 2'b01, 3'b000, 32'h300, 32'h0, 32'h0, 32'h20);
    expect_rsp("jal", 1'b1, 32'h320, 32'h320, 32'h304, 1'b0, 1'b0);
    retire("jal");

    // Not-taken BNE with misaligned target reports misaligned=0
    issue("bne_nt", 2'b00, 3'b001, 32'h10, 32'h5, 32'h5, 32'h6);
    expect_rsp("bne_nt", 1'b0, 32'h16, 32'h14, 32'h0, 1'b0, 1'b0);
    retire("bne_nt");

    // Backpressure with a second request waiting
    issue("bgeu", 2'b00, 3'b111, 32'h400, 32'h5, 32'h5, 32'h8);
    drive(2'b00, 3'b101, 32'h500, 32'hFFFF_FFFE, 32'h3, 32'h40);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp.valid",   rsp_valid, 1'b1);
      chk("bp.ready",   req_ready, 1'b0);
      chk("bp.pc_next", rsp_pc_next, 32'h408);
      chk("bp.target",  rsp_target, 32'h408);
      chk("bp.taken",   rsp_taken, 1'b1);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("bp.valid_retired", rsp_valid, 1'b0);
    chk("bp.ready_retired", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    chk("bp.second_eval_ready", req_ready, 1'b0);
    chk("bp.second_eval_valid", rsp_valid, 1'b0);
    cyc();
    chk("bp.second_valid", rsp_valid, 1'b1);
    expect_rsp("bge2", 1'b0, 32'h540, 32'h504, 32'h0, 1'b0, 1'b0);
    retire("bge2");

    // Illegal funct3 and reserved kind
    issue("ill_f3", 2'b00, 3'b010, 32'h600, 32'h7, 32'h7, 32'h8);
    expect_rsp("ill_f3", 1'b0, 32'h608, 32'h604, 32'h0, 1'b0, 1'b1);
    retire("ill_f3");
    issue("ill_kind", 2'b11, 3'b000, 32'h700, 32'h1, 32'h1, 32'h8);
    chk("ill_kind.illegal", rsp_illegal, 1'b1);
    chk("ill_kind.taken",   rsp_taken, 1'b0);
    chk("ill_kind.pc_next", rsp_pc_next, 32'h704);
    retire("ill_kind");

    // Reset while in EVAL discards the operation
    drive(2'b00, 3'b000, 32'h800, 32'h1, 32'h1, 32'h10);
    cyc();
    req_valid = 1'b0;
    chk("rst_eval.valid_eval", rsp_valid, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_eval.ready", req_ready, 1'b1);
    chk("rst_eval.valid", rsp_valid, 1'b0);
    cyc();
    chk("rst_eval.valid2", rsp_valid, 1'b0);
    chk("rst_eval.pc_next", rsp_pc_next, 32'h0);
    cyc();
    chk("rst_eval.valid3", rsp_valid, 1'b0);

    // Predictor: counters start at 01 after the reset above
    issue("pred1", 2'b00, 3'b001, 32'h40, 32'h1, 32'h2, 32'h8);
    expect_rsp("pred1", 1'b1, 32'h48, 32'h48, 32'h0, 1'b0, 1'b0);
    chk("pred1.pred",    rsp_pred_taken, 1'b0);
    chk("pred1.mispred", rsp_mispredict, PRED_ON);
    retire("pred1");
    issue("pred2", 2'b00, 3'b001, 32'h40, 32'h1, 32'h2, 32'h8);
    chk("pred2.taken",   rsp_taken, 1'b1);
    chk("pred2.pred",    rsp_pred_taken, PRED_ON);
    chk("pred2.mispred", rsp_mispredict, 1'b0);
    retire("pred2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
